sprite_coll_sched: RTL
======================

Name: sprite_coll_sched

Overview:
- Per-frame collision scheduler for the maze game. On each frame start it latches the player sprite position and walks an obstacle table of NUM_OBJ entries through a single shared box comparator, one entry per clock.
- It reports a registered hit flag, the lowest hit index and a per-entry hit mask to the player movement logic.
- It replaces one hard-wired comparator per obstacle with a single time-shared comparator.

Parameters:
- NUM_OBJ, 8, number of obstacle table entries scanned per frame (2..16)
- IDX_W, 3, width of the obstacle index; must equal clog2(NUM_OBJ)
- Y_OFF, 20, vertical offset added to the player y before comparison
- DY_MAX, 40, inclusive upper bound on the y distance for a hit
- DX_MAX, 20, inclusive upper bound on the x distance for a hit

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  single-cycle pulse at frame boundary; starts a scan
- sprite_xpos  in  20  player x, sampled on the accepted frame_start
- sprite_ypos  in  20  player y, sampled on the accepted frame_start
- obj_addr  out  IDX_W  obstacle table read address
- obj_xpos  in  20  entry x; valid the cycle after obj_addr is presented
- obj_ypos  in  20  entry y; same timing as obj_xpos
- obj_en  in  1  entry is active; same timing as obj_xpos
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- coll_valid  out  1  one-cycle pulse when the results update
- sprite_coll  out  1  held result: any entry hit in the last completed scan
- coll_idx  out  IDX_W  held result: lowest hit index; 0 when there is no hit
- hit_mask  out  NUM_OBJ  held result: bit i set if entry i hit

Behaviour:
- Reset (async assert, sync deassert):
  - state IDLE
  - all outputs 0, including obj_addr
  - latched position and accumulators cleared
- Reset during a scan aborts it. No coll_valid is issued, and the held results read 0 afterwards.
- States and transitions:
  - IDLE: frame_start=1 -> SCAN. Latch px=sprite_xpos and py=sprite_ypos. Set obj_addr=0, clear accumulators.
  - SCAN: obj_addr increments each cycle. After obj_addr=NUM_OBJ-1 has been presented -> DRAIN.
  - DRAIN: evaluates the last entry -> DONE.
  - DONE: copies the accumulators to sprite_coll, coll_idx and hit_mask, pulses coll_valid for one cycle -> IDLE.
- Read pipeline: entry i data arrive the cycle after obj_addr=i. A delayed-address register tags each compare with its index.
- Latency: frame_start sampled at edge t -> coll_valid high in the cycle after edge t+NUM_OBJ+2. busy is high for NUM_OBJ+2 cycles.
- Comparator arithmetic (20-bit modulo, unsigned):
  - DY = (py + Y_OFF) - obj_ypos
  - DX = px - obj_xpos
  - hit = obj_en && DY <= DY_MAX && DX <= DX_MAX
  - A negative difference wraps to a large value and is therefore a miss.
  - Both bounds are inclusive.
- Accumulation: hit_mask_acc[i] is set on a hit for entry i. coll_idx_acc is written only on the first hit of the scan, giving the lowest index.
- frame_start while busy is ignored; the current scan completes with its latched position.
- Player position changes during a scan have no effect.
- Held outputs keep their values until the next DONE. sprite_coll is a level signal for the movement logic.
- obj_en=0 entries never hit, whatever their coordinates.
- No hit in a scan -> sprite_coll=0, coll_idx=0, hit_mask=0. Results are still pulsed with coll_valid.

Decomposition:
- Package sprite_pkg holds:
  - the state enum {IDLE, SCAN, DRAIN, DONE}
  - the 20-bit position typedef pos_t
  - default constants Y_OFF, DY_MAX, DX_MAX
- Sub-module sprite_box_cmp is the combinational single-entry overlap check. Inputs are px, py, ox, oy and en; the output is hit. Parameters are the three constants.
- The scheduler holds the FSM, address counter, index pipeline register and accumulators.

Test Plan:
- Player (100,100), entry 2 = (90,90) en=1, all others en=0, pulse frame_start -> coll_valid after NUM_OBJ+2 cycles; sprite_coll=1, coll_idx=2, hit_mask=8'h04.
- Entry 0 = (80,100) (DX=20) and entry 1 = (79,100) (DX=21), player (100,100) -> hit_mask=8'h01. Then entry 0 = (100,80) (DY=40) and entry 1 = (100,79) (DY=41) -> hit_mask=8'h01.
- Player (100,100), entry 3 = (101,100) (DX wraps) and entry 4 = (100,121) (DY wraps) -> sprite_coll=0, coll_idx=0, hit_mask=0.
- Entries 5 and 6 both at (95,100), en=1, player (100,100) -> coll_idx=5, hit_mask=8'h60. Same coordinates with en=0 -> no hit.
- Second frame_start 3 cycles into a scan, with sprite_xpos changed to 500 -> ignored; exactly one coll_valid, results reflect the original position, busy is high for exactly NUM_OBJ+2 cycles.
- Reset_n driven low mid-SCAN -> outputs 0 at once, no coll_valid. A fresh frame_start after release completes normally.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and default constants for the sprite collision scheduler.
package sprite_pkg;

    localparam int unsigned POS_W  = 20;
    localparam int unsigned Y_OFF  = 20;
    localparam int unsigned DY_MAX = 40;
    localparam int unsigned DX_MAX = 20;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_box_cmp.sv
// Single-entry box overlap check; differences are modulo 2^20, so a negative
// difference wraps to a large value and never satisfies the bound.
module sprite_box_cmp #(
    parameter int unsigned Y_OFF  = sprite_pkg::Y_OFF,
    parameter int unsigned DY_MAX = sprite_pkg::DY_MAX,
    parameter int unsigned DX_MAX = sprite_pkg::DX_MAX
) (
    input  sprite_pkg::pos_t px,
    input  sprite_pkg::pos_t py,
    input  sprite_pkg::pos_t ox,
    input  sprite_pkg::pos_t oy,
    input  logic             en,
    output logic             hit
);

    localparam int unsigned POS_W = sprite_pkg::POS_W;

    logic [POS_W-1:0] w_dy;
    logic [POS_W-1:0] w_dx;

    // Wrapping distances and inclusive bound test.
    always_comb begin
        w_dy = py + POS_W'(Y_OFF) - oy;
        w_dx = px - ox;
        hit  = en && (w_dy <= POS_W'(DY_MAX)) && (w_dx <= POS_W'(DX_MAX));
    end

endmodule

// File: rtl/sprite_coll_sched.sv
// Per-frame collision scheduler: walks the obstacle table through one shared
// comparator, one entry per clock, and publishes held hit results.
module sprite_coll_sched #(
    parameter int unsigned NUM_OBJ = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned Y_OFF   = sprite_pkg::Y_OFF,
    parameter int unsigned DY_MAX  = sprite_pkg::DY_MAX,
    parameter int unsigned DX_MAX  = sprite_pkg::DX_MAX
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic [19:0]        sprite_xpos,
    input  logic [19:0]        sprite_ypos,
    output logic [IDX_W-1:0]   obj_addr,
    input  logic [19:0]        obj_xpos,
    input  logic [19:0]        obj_ypos,
    input  logic               obj_en,
    output logic               busy,
    output logic               coll_valid,
    output logic               sprite_coll,
    output logic [IDX_W-1:0]   coll_idx,
    output logic [NUM_OBJ-1:0] hit_mask
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    sprite_pkg::state_t r_state;
    sprite_pkg::state_t w_state_nxt;
    logic               w_start;
    logic               w_hit;

    sprite_pkg::pos_t   r_px;
    sprite_pkg::pos_t   r_py;
    logic [IDX_W-1:0]   r_addr;
    logic               r_rd_vld;
    logic [IDX_W-1:0]   r_rd_idx;
    logic               r_any_acc;
    logic [IDX_W-1:0]   r_idx_acc;
    logic [NUM_OBJ-1:0] r_mask_acc;

    logic               r_busy;
    logic               r_coll_valid;
    logic               r_sprite_coll;
    logic [IDX_W-1:0]   r_coll_idx;
    logic [NUM_OBJ-1:0] r_hit_mask;

    assign obj_addr    = r_addr;
    assign busy        = r_busy;
    assign coll_valid  = r_coll_valid;
    assign sprite_coll = r_sprite_coll;
    assign coll_idx    = r_coll_idx;
    assign hit_mask    = r_hit_mask;

    sprite_box_cmp #(
        .Y_OFF  (Y_OFF),
        .DY_MAX (DY_MAX),
        .DX_MAX (DX_MAX)
    ) u_cmp (
        .px  (r_px),
        .py  (r_py),
        .ox  (obj_xpos),
        .oy  (obj_ypos),
        .en  (obj_en),
        .hit (w_hit)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= sprite_pkg::IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; frame_start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            sprite_pkg::IDLE: begin
                if (frame_start) begin
                    w_state_nxt = sprite_pkg::SCAN;
                    w_start     = 1'b1;
                end
            end
            sprite_pkg::SCAN:  if (r_addr == LAST_IDX) w_state_nxt = sprite_pkg::DRAIN;
            sprite_pkg::DRAIN: w_state_nxt = sprite_pkg::DONE;
            sprite_pkg::DONE:  w_state_nxt = sprite_pkg::IDLE;
            default:           w_state_nxt = sprite_pkg::IDLE;
        endcase
    end

    // Position latch, address counter and read-index tag pipeline.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_px     <= '0;
            r_py     <= '0;
            r_addr   <= '0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
        end else begin
            r_rd_vld <= (r_state == sprite_pkg::SCAN);
            r_rd_idx <= r_addr;
            if (w_start) begin
                r_px   <= sprite_xpos;
                r_py   <= sprite_ypos;
                r_addr <= '0;
            end else if ((r_state == sprite_pkg::SCAN) && (r_addr != LAST_IDX)) begin
                r_addr <= r_addr + IDX_W'(1);
            end
        end
    end

    // Hit accumulation; the index is captured only on the first hit of a scan.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_any_acc  <= 1'b0;
            r_idx_acc  <= '0;
            r_mask_acc <= '0;
        end else if (w_start) begin
            r_any_acc  <= 1'b0;
            r_idx_acc  <= '0;
            r_mask_acc <= '0;
        end else if (r_rd_vld && w_hit) begin
            r_mask_acc[r_rd_idx] <= 1'b1;
            if (!r_any_acc) begin
                r_any_acc <= 1'b1;
                r_idx_acc <= r_rd_idx;
            end
        end
    end

    // Registered status and held results, published in DONE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_busy        <= 1'b0;
            r_coll_valid  <= 1'b0;
            r_sprite_coll <= 1'b0;
            r_coll_idx    <= '0;
            r_hit_mask    <= '0;
        end else begin
            r_busy       <= (w_state_nxt != sprite_pkg::IDLE);
            r_coll_valid <= (r_state == sprite_pkg::DONE);
            if (r_state == sprite_pkg::DONE) begin
                r_sprite_coll <= r_any_acc;
                r_coll_idx    <= r_idx_acc;
                r_hit_mask    <= r_mask_acc;
            end
        end
    end

endmodule
